// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the unified instruction/data memory port sequencer.
// Holds the FSM states, the requester identities and the full-word byte enable.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way request picker: fixed LS priority or round-robin against last_owner.
// At most one grant is ever asserted.
module mem_arb_pick
    import riscv_mem_pkg::*;
#(
    parameter int LS_PRIORITY = 1
) (
    input  logic   req_if,
    input  logic   req_ls,
    input  owner_t last_owner,
    output logic   gnt_if,
    output logic   gnt_ls,
    output owner_t winner
);

    always_comb begin
        winner = OWN_IF;
        if (req_ls && !req_if) begin
            winner = OWN_LS;
        end else if (req_ls && req_if) begin
            // On a tie the round-robin favours whoever did not own the port last
            if (LS_PRIORITY != 0) begin
                winner = OWN_LS;
            end else begin
                winner = (last_owner == OWN_LS) ? OWN_IF : OWN_LS;
            end
        end
        gnt_if = req_if && (winner == OWN_IF);
        gnt_ls = req_ls && (winner == OWN_LS);
    end

endmodule

// File: rtl/mem_port_sequencer.sv
// Shares one memory port between instruction fetch and load/store: arbitrate,
// hold the registered request until ack (or watchdog timeout), then respond.
module mem_port_sequencer
    import riscv_mem_pkg::*;
#(
    parameter int LS_PRIORITY = 1,
    parameter int TIMEOUT     = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [3:0]  ls_be,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] rdata,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_reg, state_next;
    owner_t           owner_reg, last_owner_reg, winner;
    logic             we_reg;
    logic [31:0]      addr_reg, wdata_reg, rdata_reg;
    logic [3:0]       be_reg;
    logic [CNT_W-1:0] wdog_reg;
    logic             err_reg;
    logic             idle, timeout, pick_if, pick_ls;

    assign idle    = (state_reg == IDLE);
    assign timeout = (state_reg == ACCESS) && !mem_ack && (wdog_reg == WDOG_LAST);

    mem_arb_pick #(
        .LS_PRIORITY(LS_PRIORITY)
    ) u_pick (
        .req_if    (if_req && idle),
        .req_ls    (ls_req && idle),
        .last_owner(last_owner_reg),
        .gnt_if    (pick_if),
        .gnt_ls    (pick_ls),
        .winner    (winner)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (pick_if || pick_ls) state_next = ACCESS;
            ACCESS:  if (mem_ack || timeout) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_reg      <= OWN_IF;
            last_owner_reg <= OWN_LS;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            be_reg         <= '0;
            wdog_reg       <= '0;
            rdata_reg      <= '0;
            err_reg        <= 1'b0;
        end else begin
            if (pick_if || pick_ls) begin
                owner_reg      <= winner;
                last_owner_reg <= winner;
                wdog_reg       <= '0;
                if (winner == OWN_IF) begin
                    we_reg    <= 1'b0;
                    addr_reg  <= if_addr & ~32'h3;
                    wdata_reg <= '0;
                    be_reg    <= BE_WORD;
                end else begin
                    we_reg    <= ls_we;
                    addr_reg  <= ls_addr & ~32'h3;
                    wdata_reg <= ls_wdata;
                    be_reg    <= ls_be;
                end
            end
            if (state_reg == ACCESS) begin
                // An ack in the timeout cycle still completes the access normally
                if (mem_ack) begin
                    rdata_reg <= we_reg ? 32'h0 : mem_rdata;
                    err_reg   <= 1'b0;
                end else if (timeout) begin
                    rdata_reg <= '0;
                    err_reg   <= 1'b1;
                end else begin
                    wdog_reg <= wdog_reg + 1'b1;
                end
            end
        end
    end

    assign if_gnt    = pick_if;
    assign ls_gnt    = pick_ls;
    assign if_rvalid = (state_reg == RESP) && (owner_reg == OWN_IF);
    assign ls_rvalid = (state_reg == RESP) && (owner_reg == OWN_LS);
    assign rdata     = rdata_reg;
    assign err       = err_reg;
    assign mem_req   = (state_reg == ACCESS);
    assign mem_we    = we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign mem_be    = be_reg;
    assign busy      = !idle;

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Directed bench: dut_a uses LS priority with a 4-cycle watchdog, dut_b uses
// round-robin arbitration; both share reset, clock and payload inputs.
module tb_mem_port_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
    logic        ls_we;
    logic [3:0]  ls_be;

    logic        if_req_a, ls_req_a, mem_ack_a;
    logic        if_gnt_a, ls_gnt_a, if_rvalid_a, ls_rvalid_a, err_a, mem_req_a, mem_we_a, busy_a;
    logic [31:0] rdata_a, mem_addr_a, mem_wdata_a;
    logic [3:0]  mem_be_a;

    logic        if_req_b, ls_req_b, mem_ack_b;
    logic        if_gnt_b, ls_gnt_b, if_rvalid_b, ls_rvalid_b, err_b, mem_req_b, mem_we_b, busy_b;
    logic [31:0] rdata_b, mem_addr_b, mem_wdata_b;
    logic [3:0]  mem_be_b;

    int total_cnt  = 0;
    int passed_cnt = 0;

    always #5 clk = ~clk;

    mem_port_sequencer #(.LS_PRIORITY(1), .TIMEOUT(4), .CNT_W(8)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req_a), .if_addr(if_addr), .if_gnt(if_gnt_a), .if_rvalid(if_rvalid_a),
        .ls_req(ls_req_a), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
        .ls_gnt(ls_gnt_a), .ls_rvalid(ls_rvalid_a), .rdata(rdata_a), .err(err_a),
        .mem_req(mem_req_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
        .mem_be(mem_be_a), .mem_ack(mem_ack_a), .mem_rdata(mem_rdata), .busy(busy_a)
    );

    mem_port_sequencer #(.LS_PRIORITY(0), .TIMEOUT(255), .CNT_W(8)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req_b), .if_addr(if_addr), .if_gnt(if_gnt_b), .if_rvalid(if_rvalid_b),
        .ls_req(ls_req_b), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
        .ls_gnt(ls_gnt_b), .ls_rvalid(ls_rvalid_b), .rdata(rdata_b), .err(err_b),
        .mem_req(mem_req_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_be(mem_be_b), .mem_ack(mem_ack_b), .mem_rdata(mem_rdata), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            passed_cnt++;
            $display("check %-18s observed=%h expected=%h ok", tag, obs, exp);
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit observed=expired expected=finish");
        $fatal(1, "time limit");
    end

    initial begin
        reset_n = 1'b0;
        if_req_a = 0; ls_req_a = 0; mem_ack_a = 0;
        if_req_b = 0; ls_req_b = 0; mem_ack_b = 0;
        if_addr = 0; ls_addr = 0; ls_wdata = 0; ls_be = 0; ls_we = 0; mem_rdata = 0;
        #2;
        chk("rst_busy", busy_a, 0);
        chk("rst_mem_req", mem_req_a, 0);
        chk("rst_rdata", rdata_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_mem_addr", mem_addr_a, 0);
        chk("rst_mem_be", mem_be_a, 0);
        nxt();
        reset_n = 1'b1;

        // Single fetch, ack in cycle 3
        if_req_a = 1; if_addr = 32'h0000_0106;
        smp(); chk("t1_if_gnt", if_gnt_a, 1); chk("t1_ls_gnt", ls_gnt_a, 0); chk("t1_req_c0", mem_req_a, 0);
        nxt(); if_req_a = 0;
        smp(); chk("t1_req_c1", mem_req_a, 1); chk("t1_addr", mem_addr_a, 32'h104);
        chk("t1_be", mem_be_a, 4'hF); chk("t1_we", mem_we_a, 0); chk("t1_if_gnt_acc", if_gnt_a, 0);
        nxt();
        smp(); chk("t1_req_c2", mem_req_a, 1);
        nxt(); mem_ack_a = 1; mem_rdata = 32'h0051_0093;
        smp(); chk("t1_req_c3", mem_req_a, 1); chk("t1_rvalid_c3", if_rvalid_a, 0);
        nxt(); mem_ack_a = 0; mem_rdata = 32'h7777_7777;
        smp(); chk("t1_if_rvalid", if_rvalid_a, 1); chk("t1_ls_rvalid", ls_rvalid_a, 0);
        chk("t1_rdata", rdata_a, 32'h0051_0093); chk("t1_err", err_a, 0); chk("t1_req_c4", mem_req_a, 0);
        nxt();
        smp(); chk("t1_rvalid_c5", if_rvalid_a, 0); chk("t1_busy_c5", busy_a, 0); chk("t1_rdata_hold", rdata_a, 32'h0051_0093);

        // Store, zero-wait memory
        nxt(); ls_req_a = 1; ls_we = 1; ls_addr = 32'h100; ls_wdata = 32'hDEAD_BEEF; ls_be = 4'b0011;
        smp(); chk("t2_ls_gnt", ls_gnt_a, 1); chk("t2_if_gnt", if_gnt_a, 0); chk("t2_busy_c0", busy_a, 0);
        nxt(); ls_req_a = 0; mem_ack_a = 1; mem_rdata = 32'h1234_5678;
        smp(); chk("t2_req", mem_req_a, 1); chk("t2_we", mem_we_a, 1); chk("t2_addr", mem_addr_a, 32'h100);
        chk("t2_wdata", mem_wdata_a, 32'hDEAD_BEEF); chk("t2_be", mem_be_a, 4'b0011); chk("t2_busy_c1", busy_a, 1);
        nxt(); mem_ack_a = 0;
        smp(); chk("t2_ls_rvalid", ls_rvalid_a, 1); chk("t2_if_rvalid", if_rvalid_a, 0);
        chk("t2_rdata", rdata_a, 0); chk("t2_err", err_a, 0); chk("t2_busy_c2", busy_a, 1); chk("t2_req_c2", mem_req_a, 0);
        nxt();
        smp(); chk("t2_busy_c3", busy_a, 0); chk("t2_ls_rvalid_c3", ls_rvalid_a, 0);

        // Tie with LS priority: LS first, then IF
        nxt(); if_req_a = 1; ls_req_a = 1; ls_we = 0; ls_addr = 32'h208; if_addr = 32'h40;
        smp(); chk("t3_ls_gnt", ls_gnt_a, 1); chk("t3_if_gnt", if_gnt_a, 0);
        nxt(); ls_req_a = 0; mem_ack_a = 1; mem_rdata = 32'hAAAA_5555;
        smp(); chk("t3_if_gnt_acc", if_gnt_a, 0); chk("t3_addr_ls", mem_addr_a, 32'h208);
        nxt(); mem_ack_a = 0;
        smp(); chk("t3_ls_rvalid", ls_rvalid_a, 1); chk("t3_rdata_ls", rdata_a, 32'hAAAA_5555); chk("t3_if_gnt_resp", if_gnt_a, 0);
        nxt();
        smp(); chk("t3_if_gnt2", if_gnt_a, 1); chk("t3_ls_gnt2", ls_gnt_a, 0);
        nxt(); if_req_a = 0; mem_ack_a = 1; mem_rdata = 32'h0000_0013;
        smp(); chk("t3_addr_if", mem_addr_a, 32'h40); chk("t3_be_if", mem_be_a, 4'hF);
        nxt(); mem_ack_a = 0;
        smp(); chk("t3_if_rvalid", if_rvalid_a, 1); chk("t3_rdata_if", rdata_a, 32'h0000_0013);
        nxt();

        // Watchdog timeout with ack held low
        if_req_a = 1; if_addr = 32'h200;
        smp(); chk("t5_gnt", if_gnt_a, 1);
        for (int c = 1; c <= 4; c++) begin
            nxt(); if_req_a = 0;
            smp(); chk($sformatf("t5_req_c%0d", c), mem_req_a, 1); chk($sformatf("t5_rv_c%0d", c), if_rvalid_a, 0);
        end
        nxt();
        smp(); chk("t5_req_c5", mem_req_a, 0); chk("t5_rvalid", if_rvalid_a, 1);
        chk("t5_err", err_a, 1); chk("t5_rdata", rdata_a, 0);
        nxt();
        smp(); chk("t5_busy_c6", busy_a, 0); chk("t5_err_hold", err_a, 1);

        // Ack in the last ACCESS cycle beats the timeout
        nxt(); if_req_a = 1; if_addr = 32'h400;
        smp(); chk("t5b_gnt", if_gnt_a, 1);
        nxt(); if_req_a = 0;
        nxt();
        nxt();
        nxt(); mem_ack_a = 1; mem_rdata = 32'hCAFE_F00D;
        smp(); chk("t5b_req_c4", mem_req_a, 1);
        nxt(); mem_ack_a = 0;
        smp(); chk("t5b_rvalid", if_rvalid_a, 1); chk("t5b_err", err_a, 0); chk("t5b_rdata", rdata_a, 32'hCAFE_F00D);
        nxt();

        // Stray ack while idle is ignored
        mem_ack_a = 1; mem_rdata = 32'h0BAD_0BAD;
        smp(); chk("stray_busy_c0", busy_a, 0);
        nxt(); mem_ack_a = 0;
        smp(); chk("stray_busy_c1", busy_a, 0); chk("stray_rvalid", if_rvalid_a | ls_rvalid_a, 0);
        chk("stray_rdata", rdata_a, 32'hCAFE_F00D);

        // Round-robin ties on dut_b: IF, LS, IF, LS, IF
        nxt(); if_req_b = 1; ls_req_b = 1; ls_addr = 32'h500; if_addr = 32'h600;
        for (int r = 0; r < 5; r++) begin
            smp();
            chk($sformatf("t4_if_gnt_r%0d", r), if_gnt_b, (r % 2 == 0) ? 1 : 0);
            chk($sformatf("t4_ls_gnt_r%0d", r), ls_gnt_b, (r % 2 == 1) ? 1 : 0);
            nxt(); mem_ack_b = 1; mem_rdata = 32'h1000 + r;
            smp(); chk($sformatf("t4_addr_r%0d", r), mem_addr_b, (r % 2 == 0) ? 32'h600 : 32'h500);
            nxt(); mem_ack_b = 0;
            smp();
            chk($sformatf("t4_if_rv_r%0d", r), if_rvalid_b, (r % 2 == 0) ? 1 : 0);
            chk($sformatf("t4_ls_rv_r%0d", r), ls_rvalid_b, (r % 2 == 1) ? 1 : 0);
            chk($sformatf("t4_rdata_r%0d", r), rdata_b, 32'h1000 + r);
            chk($sformatf("t4_nognt_r%0d", r), if_gnt_b | ls_gnt_b, 0);
            if (r == 4) begin
                if_req_b = 0; ls_req_b = 0;
            end
            nxt();
        end

        // Reset during ACCESS on dut_a; afterwards dut_b tie must go to IF
        if_req_a = 1; if_addr = 32'h700;
        smp(); chk("t6_gnt", if_gnt_a, 1);
        nxt(); if_req_a = 0;
        #2; chk("t6_req_before", mem_req_a, 1);
        reset_n = 1'b0;
        #1; chk("t6_req_async", mem_req_a, 0); chk("t6_busy_async", busy_a, 0);
        mem_ack_a = 1;
        nxt(); mem_ack_a = 0;
        chk("t6_rvalid_rst", if_rvalid_a | ls_rvalid_a, 0);
        reset_n = 1'b1;
        smp(); chk("t6_rvalid_after", if_rvalid_a | ls_rvalid_a, 0); chk("t6_busy_after", busy_a, 0);
        nxt(); if_req_b = 1; ls_req_b = 1;
        smp(); chk("t6_tie_if", if_gnt_b, 1); chk("t6_tie_ls", ls_gnt_b, 0);
        nxt(); if_req_b = 0; ls_req_b = 0; mem_ack_b = 1; mem_rdata = 32'h600D_600D;
        nxt(); mem_ack_b = 0;
        smp(); chk("t6_b_if_rvalid", if_rvalid_b, 1); chk("t6_b_rdata", rdata_b, 32'h600D_600D);
        nxt();

        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule
